// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its storage.
// Width helpers keep pointer/count sizing in one place.
package fifo_pkg;

    // Smallest legal depth step; depths are multiples of this.
    localparam int unsigned FIFO_DEPTH_UNIT = 1024;

    // Per-cycle operation after acceptance gating.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Pointer width: addresses 0..depth-1.
    function automatic int unsigned addr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Count width: must also hold the value depth itself.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Pack the two accept strobes into an operation code.
    function automatic fifo_op_e op_decode(input logic wr, input logic rd);
        return fifo_op_e'({wr, rd});
    endfunction

endpackage

// File: rtl/fifo_bram.sv
// Simple dual-port block RAM with registered read.
// Contents are never cleared; only written words are meaningful.
module fifo_bram
    import fifo_pkg::*;
#(
    parameter int P_DEPTH = 1024,
    parameter int P_WIDTH = 8
) (
    input  logic                             wr_clk,
    input  logic                             wr_en,
    input  logic [addr_width(P_DEPTH)-1:0]   wr_addr,
    input  logic [P_WIDTH-1:0]               wr_data,
    input  logic                             rd_clk,
    input  logic                             rd_en,
    input  logic [addr_width(P_DEPTH)-1:0]   rd_addr,
    output logic [P_WIDTH-1:0]               rd_data
);

    logic [P_WIDTH-1:0] mem [P_DEPTH];

    // Write port: store the word at the addressed slot.
    always_ff @(posedge wr_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: one-cycle registered read, held when idle.
    always_ff @(posedge rd_clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered status flags and error pulses.
// Acceptance is judged against the registered full/empty flags.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int P_DEPTH  = 1024,
    parameter int P_WIDTH  = 8,
    parameter int P_AFULL  = P_DEPTH - 4,
    parameter int P_AEMPTY = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [P_WIDTH-1:0]                wr_data,
    input  logic                              rd_en,
    output logic [P_WIDTH-1:0]                rd_data,
    output logic                              rd_valid,
    output logic                              full,
    output logic                              empty,
    output logic                              almost_full,
    output logic                              almost_empty,
    output logic [count_width(P_DEPTH)-1:0]   count,
    output logic                              overflow,
    output logic                              underflow
);

    localparam int AW = addr_width(P_DEPTH);
    localparam int CW = count_width(P_DEPTH);

    localparam logic [CW-1:0] C_DEPTH  = CW'(P_DEPTH);
    localparam logic [CW-1:0] C_AFULL  = CW'(P_AFULL);
    localparam logic [CW-1:0] C_AEMPTY = CW'(P_AEMPTY);
    localparam logic [CW-1:0] C_ONE    = CW'(1);
    localparam logic [AW-1:0] A_ONE    = AW'(1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_acc;
    logic          rd_acc;
    logic [CW-1:0] count_nxt;
    fifo_op_e      op;

    // Gate requests by flags and reset, then derive next count.
    always_comb begin
        wr_acc    = wr_en & ~full & ~rst;
        rd_acc    = rd_en & ~empty & ~rst;
        op        = op_decode(wr_acc, rd_acc);
        count_nxt = count;
        unique case (op)
            OP_WR:   count_nxt = count + C_ONE;
            OP_RD:   count_nxt = count - C_ONE;
            OP_BOTH: count_nxt = count;
            OP_IDLE: count_nxt = count;
        endcase
    end

    // Count and flags, flags decoded from the next count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            count        <= count_nxt;
            full         <= (count_nxt == C_DEPTH);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= C_AFULL);
            almost_empty <= (count_nxt <= C_AEMPTY);
        end
    end

    // Pointers advance on accepted requests and wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + A_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + A_ONE;
            end
        end
    end

    // Read-valid and one-cycle error pulses for rejected requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid  <= rd_acc;
            overflow  <= wr_en & full;
            underflow <= rd_en & empty;
        end
    end

    fifo_bram #(
        .P_DEPTH (P_DEPTH),
        .P_WIDTH (P_WIDTH)
    ) u_bram (
        .wr_clk  (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_clk  (clk),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync with a queue-based reference model.
// Outputs are compared every cycle plus literal spot checks.
module tb_fifo_sync;

    localparam int DEPTH = 1024;
    localparam int WIDTH = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [WIDTH-1:0]  wr_data;
    logic              rd_en;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [10:0]       count;
    logic              overflow;
    logic              underflow;

    always #5 clk = ~clk;

    fifo_sync #(
        .P_DEPTH (DEPTH),
        .P_WIDTH (WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mq[$];
    bit         m_valid = 0;
    bit         m_ovf = 0;
    bit         m_unf = 0;
    logic [7:0] m_data = '0;
    bit         chk_en = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply one cycle of stimulus, then advance the model past the edge.
    task automatic step(input bit r, input bit w, input logic [7:0] d,
                        input bit rd);
        int sz;
        rst     = r;
        wr_en   = w;
        wr_data = d;
        rd_en   = rd;
        sz      = mq.size();
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_valid = 0;
            m_ovf   = 0;
            m_unf   = 0;
        end else begin
            m_ovf   = w && (sz == DEPTH);
            m_unf   = rd && (sz == 0);
            m_valid = rd && (sz != 0);
            if (m_valid) m_data = mq.pop_front();
            if (w && (sz != DEPTH)) mq.push_back(d);
        end
        #1;
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("count", 32'(count), 32'(mq.size()));
            check("full", 32'(full), 32'(mq.size() == DEPTH));
            check("empty", 32'(empty), 32'(mq.size() == 0));
            check("almost_full", 32'(almost_full), 32'(mq.size() >= DEPTH - 4));
            check("almost_empty", 32'(almost_empty), 32'(mq.size() <= 4));
            check("rd_valid", 32'(rd_valid), 32'(m_valid));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("underflow", 32'(underflow), 32'(m_unf));
            if (m_valid) check("rd_data", 32'(rd_data), 32'(m_data));
        end
    end

    initial begin
        rst = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_data = '0;
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        chk_en = 1;

        // Reset state.
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_aempty", 32'(almost_empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_afull", 32'(almost_full), 0);
        check("rst_valid", 32'(rd_valid), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_unf", 32'(underflow), 0);

        // Three writes then three reads.
        step(0, 1, 8'h11, 0);
        check("w1_empty", 32'(empty), 0);
        step(0, 1, 8'h22, 0);
        step(0, 1, 8'h33, 0);
        check("w3_count", 32'(count), 3);
        step(0, 0, 8'h00, 1);
        check("r1_valid", 32'(rd_valid), 1);
        check("r1_data", 32'(rd_data), 32'h11);
        check("r1_count", 32'(count), 2);
        step(0, 0, 8'h00, 1);
        check("r2_data", 32'(rd_data), 32'h22);
        step(0, 0, 8'h00, 1);
        check("r3_data", 32'(rd_data), 32'h33);
        check("r3_count", 32'(count), 0);
        check("r3_empty", 32'(empty), 1);
        step(0, 0, 8'h00, 0);
        check("idle_valid", 32'(rd_valid), 0);

        // Read on empty.
        step(0, 0, 8'h00, 1);
        check("unf_pulse", 32'(underflow), 1);
        check("unf_valid", 32'(rd_valid), 0);
        check("unf_count", 32'(count), 0);
        step(0, 0, 8'h00, 0);
        check("unf_clear", 32'(underflow), 0);
        step(0, 1, 8'h5A, 0);
        step(0, 0, 8'h00, 1);
        check("unf_ptr_data", 32'(rd_data), 32'h5A);

        // Fill to full, then overflow.
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, 8'(i * 3 + 1), 0);
            check("fill_afull", 32'(almost_full), 32'(i + 1 >= 1020));
        end
        check("fill_full", 32'(full), 1);
        check("fill_count", 32'(count), 1024);
        step(0, 1, 8'hEE, 0);
        check("ovf_pulse", 32'(overflow), 1);
        check("ovf_count", 32'(count), 1024);
        step(0, 0, 8'h00, 0);
        check("ovf_clear", 32'(overflow), 0);

        // Simultaneous request while full.
        step(0, 1, 8'h77, 1);
        check("fullrw_valid", 32'(rd_valid), 1);
        check("fullrw_data", 32'(rd_data), 32'h01);
        check("fullrw_ovf", 32'(overflow), 1);
        check("fullrw_count", 32'(count), 1023);
        step(0, 0, 8'h00, 0);

        // Reset mid-operation at count 600.
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 600; i++) begin
            step(0, 1, 8'(i), 0);
        end
        check("c600_count", 32'(count), 600);
        step(1, 1, 8'h99, 1);
        check("mrst_count", 32'(count), 0);
        check("mrst_empty", 32'(empty), 1);
        check("mrst_valid", 32'(rd_valid), 0);
        step(0, 1, 8'hC3, 0);
        step(0, 0, 8'h00, 1);
        check("mrst_data", 32'(rd_data), 32'hC3);

        // Streaming at count 5 across pointer wrap.
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 8'(8'h80 + i), 0);
        end
        check("c5_count", 32'(count), 5);
        for (int i = 0; i < 3000; i++) begin
            step(0, 1, 8'(i), 1);
        end
        check("stream_count", 32'(count), 5);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 8'h00, 1);
        end
        check("stream_last", 32'(rd_data), 32'hB7);
        check("stream_empty", 32'(empty), 1);
        step(0, 0, 8'h00, 0);

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
